// File: rtl/mel_pkg.sv
// Shared constants for the mel spectrogram sink: default geometry, FSM state codes
// and the log2 compressor field split.
package mel_pkg;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_MEL_BANDS = 40;
    localparam int unsigned DEF_N_FRAMES  = 101;
    localparam int unsigned DEF_ADDR_W    = $clog2(DEF_MEL_BANDS * DEF_N_FRAMES);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    // Compressed word = {exponent[E_W-1:0], mantissa[F_W-1:0]}
    localparam int unsigned E_W = 4;

    function automatic int unsigned f_w(input int unsigned width);
        return width - E_W;
    endfunction

endpackage

// File: rtl/mel_spec_sink_if.sv
// Spectrogram output stream: valid/ready with frame and spectrogram end markers.
interface mel_spec_sink_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             spec_valid;
    logic             spec_ready;
    logic [WIDTH-1:0] spec_data;
    logic             spec_flast;
    logic             spec_last;

    modport master (
        output spec_valid,
        output spec_data,
        output spec_flast,
        output spec_last,
        input  spec_ready
    );

    modport slave (
        input  spec_valid,
        input  spec_data,
        input  spec_flast,
        input  spec_last,
        output spec_ready
    );

endinterface

// File: rtl/mel_log2.sv
// Registered log2 compressor: {MSB index, bits below the MSB left-aligned and truncated}.
module mel_log2
    import mel_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned F_W = f_w(WIDTH);

    logic [E_W-1:0]   expo;
    logic [WIDTH-1:0] aligned;
    logic [F_W-1:0]   frac;

    always_comb begin
        expo = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_data[i]) expo = E_W'(i);
        end
        // Shifting by WIDTH (expo = 0) clears everything, so inputs 0 and 1 map to 0.
        aligned = in_data << (WIDTH - 32'(expo));
        frac    = F_W'(aligned >> E_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= {expo, frac};
        end
    end

endmodule

// File: rtl/mel_spec_sink.sv
// Collects MEL_BANDS x N_FRAMES mel values into one RAM and drains them frame-major.
// Build option MEL_LOG2_EN inserts a one-cycle log2 compressor on the write path.
module mel_spec_sink
    import mel_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MEL_BANDS = DEF_MEL_BANDS,
    parameter int unsigned N_FRAMES  = DEF_N_FRAMES,
    parameter int unsigned ADDR_W    = $clog2(MEL_BANDS * N_FRAMES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mel_avail,
    input  logic [WIDTH-1:0]              mel_data,
    mel_spec_sink_if.master               spec,
    output logic                          spec_ovf,
    input  logic                          ovf_clr,
    output logic [$clog2(N_FRAMES+1)-1:0] frame_cnt
);

    localparam int unsigned DEPTH  = MEL_BANDS * N_FRAMES;
    localparam int unsigned BAND_W = $clog2(MEL_BANDS);
    localparam int unsigned FCNT_W = $clog2(N_FRAMES + 1);

    logic             w_avail;
    logic [WIDTH-1:0] w_data;

`ifdef MEL_LOG2_EN
    mel_log2 #(.WIDTH(WIDTH)) u_log2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (mel_avail),
        .in_data   (mel_data),
        .out_valid (w_avail),
        .out_data  (w_data)
    );
`else
    assign w_avail = mel_avail;
    assign w_data  = mel_data;
`endif

    logic [0:0]        state;
    logic [BAND_W-1:0] band_cnt;
    logic              drop_frame;
    logic [ADDR_W-1:0] wr_addr;
    logic              band0, last_band, wr_en, frame_done, drop_evt;

    assign band0      = (band_cnt == '0);
    assign last_band  = (band_cnt == BAND_W'(MEL_BANDS - 1));
    assign wr_en      = w_avail && (state == FILL) && (band0 || !drop_frame);
    assign frame_done = wr_en && last_band;
    assign drop_evt   = w_avail && band0 && (state == DRAIN);

    // Read-side pipeline: RAM read stage -> output register, with a skid slot behind it.
    logic [ADDR_W-1:0] rd_addr;
    logic [BAND_W-1:0] rd_band;
    logic              rd_done, rd_issue;
    logic              inflight, inf_flast, inf_last;
    logic [WIDTH-1:0]  ram_q;
    logic              out_v, out_flast, out_last;
    logic [WIDTH-1:0]  out_data;
    logic              skid_v, skid_flast, skid_last;
    logic [WIDTH-1:0]  skid_data;
    logic              pop, last_hs;
    logic [1:0]        occ;

    assign pop      = out_v && spec.spec_ready;
    assign last_hs  = pop && out_last;
    // Words held or in flight after this cycle's pop; capacity is two (output + skid).
    assign occ      = 2'(out_v) + 2'(skid_v) + 2'(inflight) - 2'(pop);
    assign rd_issue = (state == DRAIN) && !rd_done && (occ < 2'd2);

    assign spec.spec_valid = out_v;
    assign spec.spec_data  = out_data;
    assign spec.spec_flast = out_flast;
    assign spec.spec_last  = out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            band_cnt   <= '0;
            drop_frame <= 1'b0;
            spec_ovf   <= 1'b0;
            wr_addr    <= '0;
            frame_cnt  <= '0;
        end else begin
            if (w_avail) band_cnt <= last_band ? '0 : band_cnt + 1'b1;
            // Keep/drop is decided once per frame, on its band 0.
            if (w_avail && band0) drop_frame <= (state == DRAIN);

            if (drop_evt)     spec_ovf <= 1'b1;
            else if (ovf_clr) spec_ovf <= 1'b0;

            if (state == FILL) begin
                if (wr_en) wr_addr <= wr_addr + 1'b1;
                if (frame_done) begin
                    frame_cnt <= frame_cnt + 1'b1;
                    if (frame_cnt == FCNT_W'(N_FRAMES - 1)) state <= DRAIN;
                end
            end else if (last_hs) begin
                state     <= FILL;
                wr_addr   <= '0;
                frame_cnt <= '0;
            end
        end
    end

    logic [WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)    ram[wr_addr] <= w_data;
        if (rd_issue) ram_q        <= ram[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr    <= '0;
            rd_band    <= '0;
            rd_done    <= 1'b0;
            inflight   <= 1'b0;
            inf_flast  <= 1'b0;
            inf_last   <= 1'b0;
            out_v      <= 1'b0;
            out_data   <= '0;
            out_flast  <= 1'b0;
            out_last   <= 1'b0;
            skid_v     <= 1'b0;
            skid_data  <= '0;
            skid_flast <= 1'b0;
            skid_last  <= 1'b0;
        end else if (state == FILL) begin
            rd_addr  <= '0;
            rd_band  <= '0;
            rd_done  <= 1'b0;
            inflight <= 1'b0;
            out_v    <= 1'b0;
            skid_v   <= 1'b0;
        end else begin
            inflight <= rd_issue;
            if (rd_issue) begin
                inf_flast <= (rd_band == BAND_W'(MEL_BANDS - 1));
                inf_last  <= (rd_addr == ADDR_W'(DEPTH - 1));
                rd_addr   <= rd_addr + 1'b1;
                rd_band   <= (rd_band == BAND_W'(MEL_BANDS - 1)) ? '0 : rd_band + 1'b1;
                if (rd_addr == ADDR_W'(DEPTH - 1)) rd_done <= 1'b1;
            end

            if (!out_v || pop) begin
                if (skid_v) begin
                    out_v     <= 1'b1;
                    out_data  <= skid_data;
                    out_flast <= skid_flast;
                    out_last  <= skid_last;
                    skid_v    <= inflight;
                    if (inflight) begin
                        skid_data  <= ram_q;
                        skid_flast <= inf_flast;
                        skid_last  <= inf_last;
                    end
                end else begin
                    out_v <= inflight;
                    if (inflight) begin
                        out_data  <= ram_q;
                        out_flast <= inf_flast;
                        out_last  <= inf_last;
                    end
                end
            end else if (inflight) begin
                skid_v     <= 1'b1;
                skid_data  <= ram_q;
                skid_flast <= inf_flast;
                skid_last  <= inf_last;
            end
        end
    end

endmodule

// File: tb/tb_mel_spec_sink.sv
// Directed bench for mel_spec_sink with MEL_BANDS=4, N_FRAMES=2, WIDTH=16.
module tb_mel_spec_sink;

    localparam int unsigned W  = 16;
    localparam int unsigned MB = 4;
    localparam int unsigned NF = 2;
`ifdef MEL_LOG2_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mel_avail;
    logic [W-1:0]  mel_data;
    logic          spec_ovf;
    logic          ovf_clr;
    logic [1:0]    frame_cnt;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [15:0]   exp_words [8];

    mel_spec_sink_if #(.WIDTH(W)) spec_if ();

    mel_spec_sink #(.WIDTH(W), .MEL_BANDS(MB), .N_FRAMES(NF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mel_avail (mel_avail),
        .mel_data  (mel_data),
        .spec      (spec_if.master),
        .spec_ovf  (spec_ovf),
        .ovf_clr   (ovf_clr),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input int x);
`ifdef MEL_LOG2_EN
        int e;
        int rem;
        if (x < 2) return 16'h0000;
        e = 15;
        while (((x >> e) & 1) == 0) e--;
        rem = x - (1 << e);
        return 16'((e << 12) | ((((rem << (16 - e)) & 16'hFFFF)) >> 4));
`else
        return 16'(x);
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < 4; i++) begin
            mel_avail = 1'b1;
            mel_data  = 16'(base + i);
            step(1);
        end
        mel_avail = 1'b0;
    endtask

    task automatic fill8(input int base);
        push_frame(base);
        push_frame(base + 4);
        for (int i = 0; i < 8; i++) exp_words[i] = model(base + i);
    endtask

    task automatic drain(input string tag, input bit toggle, input int nwords);
        int k = 0;
        int cyc = 0;
        int first = -1;
        int lastc = -1;
        bit stalled = 1'b0;
        logic [15:0] held = '0;
        logic hf = 1'b0;
        logic hl = 1'b0;
        while (k < nwords && cyc < 200) begin
            spec_if.spec_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stalled)
                check({tag, " hold"},
                      {spec_if.spec_valid, spec_if.spec_data, spec_if.spec_flast, spec_if.spec_last},
                      {1'b1, held, hf, hl});
            if (spec_if.spec_valid) begin
                if (spec_if.spec_ready) begin
                    check({tag, " data"}, spec_if.spec_data, exp_words[k]);
                    check({tag, " flast"}, spec_if.spec_flast, (k % 4 == 3));
                    check({tag, " last"}, spec_if.spec_last, (k == 7));
                    if (first < 0) first = cyc;
                    lastc = cyc;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = spec_if.spec_data;
                    hf = spec_if.spec_flast;
                    hl = spec_if.spec_last;
                end
            end
            step(1);
            cyc++;
        end
        spec_if.spec_ready = 1'b0;
        check({tag, " words"}, k, nwords);
        if (!toggle) check({tag, " burst"}, lastc - first, nwords - 1);
    endtask

    initial begin
        rst_n = 1'b0;
        mel_avail = 1'b0;
        mel_data = '0;
        ovf_clr = 1'b0;
        spec_if.spec_ready = 1'b0;
        #12;
        check("rst valid", spec_if.spec_valid, 0);
        check("rst flast", spec_if.spec_flast, 0);
        check("rst last", spec_if.spec_last, 0);
        check("rst data", spec_if.spec_data, 0);
        check("rst ovf", spec_ovf, 0);
        check("rst frame_cnt", frame_cnt, 0);
        #2 rst_n = 1'b1;
        step(1);

        // 1: back-to-back fill, continuous drain
        fill8(1);
        step(LAT);
        check("t1 frame_cnt full", frame_cnt, 2);
        check("t1 valid early", spec_if.spec_valid, 0);
        step(2);
        check("t1 first valid", spec_if.spec_valid, 1);
        drain("t1", 1'b0, 8);
        check("t1 frame_cnt after", frame_cnt, 0);
        check("t1 valid after", spec_if.spec_valid, 0);

        // 2: toggling ready
        fill8(1);
        drain("t2", 1'b1, 8);
        check("t2 frame_cnt after", frame_cnt, 0);

        // 3: frame arriving during drain is dropped and flagged
        fill8(1);
        push_frame(9);
        step(LAT);
        check("t3 ovf set", spec_ovf, 1);
        check("t3 stalled head", {spec_if.spec_valid, spec_if.spec_data}, {1'b1, model(1)});
        drain("t3a", 1'b0, 8);
        check("t3 ovf sticky", spec_ovf, 1);
        fill8(13);
        step(LAT);
        drain("t3b", 1'b0, 8);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("t3 ovf cleared", spec_ovf, 0);

        // 5: clear coincident with a dropped band 0; drop spans the end of drain
        fill8(41);
        mel_avail = 1'b1;
        mel_data = 16'd50;
`ifndef MEL_LOG2_EN
        ovf_clr = 1'b1;
`endif
        step(1);
        mel_avail = 1'b0;
`ifdef MEL_LOG2_EN
        ovf_clr = 1'b1;
        step(1);
`endif
        ovf_clr = 1'b0;
        check("t5 set wins", spec_ovf, 1);
        drain("t5a", 1'b0, 8);
        for (int i = 51; i <= 53; i++) begin
            mel_avail = 1'b1;
            mel_data = 16'(i);
            step(1);
        end
        mel_avail = 1'b0;
        step(LAT);
        check("t5 tail dropped", frame_cnt, 0);
        fill8(61);
        step(LAT);
        drain("t5b", 1'b0, 8);

        // 4: asynchronous reset mid-drain
        fill8(70);
        step(LAT);
        drain("t4a", 1'b0, 5);
        check("t4 ovf before rst", spec_ovf, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t4 rst valid", spec_if.spec_valid, 0);
        check("t4 rst data", spec_if.spec_data, 0);
        check("t4 rst flast", spec_if.spec_flast, 0);
        check("t4 rst last", spec_if.spec_last, 0);
        check("t4 rst frame_cnt", frame_cnt, 0);
        check("t4 rst ovf", spec_ovf, 0);
        #2 rst_n = 1'b1;
        step(1);
        fill8(80);
        step(LAT);
        drain("t4b", 1'b0, 8);

`ifdef MEL_LOG2_EN
        // 6: log2 compression, hand-computed
        begin
            logic [15:0] vin [8];
            vin = '{16'h0000, 16'h0001, 16'h0100, 16'h0180, 16'hFFFF, 16'h0002, 16'h0003, 16'h8000};
            exp_words = '{16'h0000, 16'h0000, 16'h8000, 16'h8800, 16'hFFFF, 16'h1000, 16'h1800, 16'hF000};
            for (int i = 0; i < 8; i++) begin
                mel_avail = 1'b1;
                mel_data = vin[i];
                step(1);
            end
            mel_avail = 1'b0;
            step(LAT);
            drain("t6", 1'b0, 8);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
